// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen register-bus RTL: transfer direction encoding
// and the bus arbiter state enum.
package rggen_rtl_pkg;

    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_direction;

    typedef enum logic {
        RGGEN_BUS_ARBITER_IDLE = 1'b0,
        RGGEN_BUS_ARBITER_BUSY = 1'b1
    } rggen_bus_arbiter_state;

    // Width of a host index; kept at least one bit so a single-host build still has a register.
    function automatic int rggen_index_width(int num_hosts);
        return (num_hosts > 1) ? $clog2(num_hosts) : 1;
    endfunction

endpackage

// File: rtl/rggen_round_robin_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping
// modulo NUM_HOSTS.
module rggen_round_robin_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int NUM_HOSTS   = 2,
    localparam int INDEX_WIDTH = rggen_index_width(NUM_HOSTS)
)(
    input  logic [NUM_HOSTS-1:0]   request,
    input  logic [INDEX_WIDTH-1:0] last_grant,
    output logic                   grant_valid,
    output logic [INDEX_WIDTH-1:0] grant_index
);

    // Walk from the farthest offset to the nearest so the nearest requester is written last and wins.
    always_comb begin
        logic [NUM_HOSTS-1:0] rotated;
        int                   candidate;
        // NOTE: every output gets a default before the loop; otherwise a cycle with no request would infer a latch.
        grant_valid = 1'b0;
        grant_index = '0;
        rotated     = '0;
        candidate   = 0;
        for (int offset = NUM_HOSTS; offset >= 1; offset--) begin
            candidate = (int'(last_grant) + offset) % NUM_HOSTS;
            rotated   = request >> candidate;
            if (rotated[0]) begin
                grant_valid = 1'b1;
                grant_index = INDEX_WIDTH'(candidate);
            end
        end
    end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Round-robin, non-preemptive sharing of one register-bus port between
// NUM_HOSTS host front ends; one transfer in flight until bus_done.
module rggen_bus_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int NUM_HOSTS     = 2,
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
)(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_HOSTS-1:0]              host_request,
    input  logic [NUM_HOSTS*ADDRESS_WIDTH-1:0] host_address,
    input  logic [NUM_HOSTS-1:0]              host_direction,
    input  logic [NUM_HOSTS*DATA_WIDTH-1:0]   host_write_data,
    input  logic [NUM_HOSTS*DATA_WIDTH/8-1:0] host_write_strobe,
    output logic [NUM_HOSTS-1:0]              host_done,
    output logic [DATA_WIDTH-1:0]             host_read_data,
    output logic [1:0]                        host_status,
    output logic                              bus_request,
    output logic [ADDRESS_WIDTH-1:0]          bus_address,
    output logic                              bus_direction,
    output logic [DATA_WIDTH-1:0]             bus_write_data,
    output logic [DATA_WIDTH/8-1:0]           bus_write_strobe,
    input  logic                              bus_done,
    input  logic [DATA_WIDTH-1:0]             bus_read_data,
    input  logic [1:0]                        bus_status
);

    localparam int INDEX_WIDTH  = rggen_index_width(NUM_HOSTS);
    localparam int STROBE_WIDTH = DATA_WIDTH / 8;

    rggen_bus_arbiter_state   state;
    rggen_bus_arbiter_state   state_next;
    logic [INDEX_WIDTH-1:0]   grant_index;
    logic [INDEX_WIDTH-1:0]   grant_index_next;
    logic [INDEX_WIDTH-1:0]   last_grant;
    logic [INDEX_WIDTH-1:0]   last_grant_next;
    logic                     arbiter_valid;
    logic [INDEX_WIDTH-1:0]   arbiter_index;
    logic                     granted_request;

    rggen_round_robin_arbiter #(
        .NUM_HOSTS  (NUM_HOSTS)
    ) u_round_robin_arbiter (
        .request     (host_request),
        .last_grant  (last_grant),
        .grant_valid (arbiter_valid),
        .grant_index (arbiter_index)
    );

    assign granted_request = host_request[grant_index];

    // Reset leaves last_grant on the highest index so host 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state       <= RGGEN_BUS_ARBITER_IDLE;
            grant_index <= '0;
            last_grant  <= INDEX_WIDTH'(NUM_HOSTS - 1);
        end else begin
            state       <= state_next;
            grant_index <= grant_index_next;
            last_grant  <= last_grant_next;
        end
    end

    always_comb begin
        state_next       = state;
        grant_index_next = grant_index;
        last_grant_next  = last_grant;
        host_done        = '0;
        host_read_data   = bus_read_data;
        host_status      = bus_status;
        bus_request      = 1'b0;
        bus_address      = '0;
        bus_direction    = 1'b0;
        bus_write_data   = '0;
        bus_write_strobe = '0;
        case (state)
            RGGEN_BUS_ARBITER_IDLE: begin
                if (arbiter_valid) begin
                    grant_index_next = arbiter_index;
                    state_next       = RGGEN_BUS_ARBITER_BUSY;
                end
            end
            RGGEN_BUS_ARBITER_BUSY: begin
                bus_request            = granted_request;
                bus_address            = host_address[int'(grant_index)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                bus_direction          = host_direction[grant_index];
                bus_write_data         = host_write_data[int'(grant_index)*DATA_WIDTH +: DATA_WIDTH];
                bus_write_strobe       = host_write_strobe[int'(grant_index)*STROBE_WIDTH +: STROBE_WIDTH];
                host_done[grant_index] = bus_done;
                // A withdrawn request ends the transfer without a done, same as a normal completion otherwise.
                if (bus_done || !granted_request) begin
                    last_grant_next = grant_index;
                    state_next      = RGGEN_BUS_ARBITER_IDLE;
                end
            end
        endcase
    end

endmodule
